// File: rtl/shift_rows_pipe.sv
// Elastic Rijndael ShiftRows/InvShiftRows stage with STAGES valid/ready registers.
// Define SHIFT_ROWS_INV_EN to select forward/inverse mapping per block via in_inv.
module shift_rows_pipe #(
    parameter int NB     = 4,
    parameter int STAGES = 1,
    localparam int BW    = 32 * NB
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [BW-1:0] in_data,
    input  logic          in_inv,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [BW-1:0] out_data,
    output logic          out_inv,
    output logic [15:0]   blk_cnt
);

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end

    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("shift_rows_pipe: STAGES must be in 1..4");
    end

    logic [BW-1:0]     w_fwd;
    logic [BW-1:0]     w_perm;
    logic [STAGES:0]   w_ready;
    logic [STAGES-1:0] r_valid;
    logic [BW-1:0]     r_data [STAGES];
    logic [15:0]       r_cnt;

`ifdef SHIFT_ROWS_INV_EN
    logic [BW-1:0]     w_inv;
    logic [STAGES-1:0] r_inv;
`endif

    // Byte k = 4*c + r sits at bits [BW-1-8k -: 8]; NB=8 skips offset 2.
    for (genvar c = 0; c < NB; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int OFF = (NB == 8 && r >= 2) ? r + 1 : r;
            localparam int SF  = (c + OFF) % NB;
            assign w_fwd[BW-1-8*(4*c+r) -: 8] = in_data[BW-1-8*(4*SF+r) -: 8];
`ifdef SHIFT_ROWS_INV_EN
            localparam int SI  = (c - OFF + NB) % NB;
            assign w_inv[BW-1-8*(4*c+r) -: 8] = in_data[BW-1-8*(4*SI+r) -: 8];
`endif
        end
    end

`ifdef SHIFT_ROWS_INV_EN
    assign w_perm = in_inv ? w_inv : w_fwd;
`else
    logic w_unused_inv;
    assign w_unused_inv = in_inv;
    assign w_perm       = w_fwd;
`endif

    always_comb begin
        w_ready         = '0;
        w_ready[STAGES] = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            w_ready[i] = ~r_valid[i] | w_ready[i+1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_cnt   <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            if (w_ready[0]) begin
                r_valid[0] <= in_valid;
                if (in_valid) begin
                    r_data[0] <= w_perm;
                end
            end
            for (int i = 1; i < STAGES; i++) begin
                if (w_ready[i]) begin
                    r_valid[i] <= r_valid[i-1];
                    if (r_valid[i-1]) begin
                        r_data[i] <= r_data[i-1];
                    end
                end
            end
            if (out_valid && out_ready) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

`ifdef SHIFT_ROWS_INV_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inv <= '0;
        end else begin
            if (w_ready[0] && in_valid) begin
                r_inv[0] <= in_inv;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (w_ready[i] && r_valid[i-1]) begin
                    r_inv[i] <= r_inv[i-1];
                end
            end
        end
    end

    assign out_inv = r_inv[STAGES-1];
`else
    assign out_inv = 1'b0;
`endif

    // Ready is combinational from out_ready; gated low while in reset.
    assign in_ready  = w_ready[0] & ~rst;
    assign out_valid = r_valid[STAGES-1];
    assign out_data  = r_data[STAGES-1];
    assign blk_cnt   = r_cnt;

endmodule
